ro_measure_ctrl: RTL and testbench
==================================

// Module: ro_measure_ctrl
// PURPOSE
//   Measurement engine feeding the ROs AXI4-Lite register slave: enables one selected ring oscillator and counts its
//   rising edges over a programmed window of ACLK cycles. It hands the count to the register block over a valid/ready pair.
//   Control inputs (start, ro_sel, window_cycles) are driven from the slave's write registers.
//   The result is consumed into a read register.
// PARAMETERS
//   NUM_RO        8    number of ring oscillators attached
//   SEL_W         4    width of ro_sel (must satisfy 2**SEL_W >= NUM_RO)
//   WIN_W         24   width of window_cycles
//   CNT_W         32   width of result_count
//   SETTLE_CYC    16   ACLK cycles between ro_en assertion and start of counting
// PORTS
//   ACLK           in   1       single clock, all logic rising-edge
//   ARESET         in   1       synchronous, active-high reset
//   ro_in          in   NUM_RO  raw RO outputs, asynchronous to ACLK
//   start          in   1       one-cycle request pulse
//   ro_sel         in   SEL_W   RO index, sampled with start
//   window_cycles  in   WIN_W   count window in ACLK cycles, sampled with start
//   ro_en          out  NUM_RO  one-hot oscillator enable
//   busy           out  1       high from accepted start until result handshake completes
//   result_valid   out  1       result available
//   result_ready   in   1       consumer accepts result
//   result_count   out  CNT_W   rising edges counted in window
//   result_sel     out  SEL_W   ro_sel of this result
//   result_ovf     out  1       counter saturated during window
//   result_err     out  1       ro_sel >= NUM_RO
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters 0, sync flops 0. ARESET mid-measurement aborts immediately; no result issued.
//   FSM: IDLE -start-> SETTLE -SETTLE_CYC elapsed-> MEASURE -window done-> DONE -valid&ready-> IDLE.
//   IDLE: start latches ro_sel and window_cycles, sets busy the next cycle. start in any other state is ignored.
//   Out-of-range ro_sel: go directly to DONE with count=0, err=1. ro_en stays 0.
//   window_cycles==0: run SETTLE, skip MEASURE, and go to DONE with count=0.
//   SETTLE: ro_en[sel]=1 from the first SETTLE cycle through the end of MEASURE. It is 0 in IDLE and DONE.
//   Sync: selected ro_in goes through a 2-flop synchroniser (s1,s2) plus a history flop s3. Edge = s2 & ~s3.
//   Sync flops run continuously; mux is applied before the synchroniser.
//   MEASURE lasts exactly window_cycles ACLK cycles. An edge is counted only in cycles where the FSM is MEASURE.
//   Edges still in the sync pipe at window end are dropped.
//   Counter is zeroed on entry to MEASURE. It saturates at 2**CNT_W-1; ovf is sticky for that measurement.
//   DONE: result_count/sel/ovf/err registered and stable and result_valid=1 until the cycle result_ready=1.
//   Next cycle: valid=0, busy=0, FSM=IDLE. result_* hold their last values until the next DONE.
//   Measurable RO frequency must be < ACLK/2; faster inputs alias (not detected).
//   Latency from start to result_valid: 1 + SETTLE_CYC + window_cycles + 1 cycles (ready held high).
// TESTING
//   1. ro_in[2] toggles every 5 ACLK cycles (period 10), sel=2, window=1000 -> count 100+/-1, ovf=0, err=0, result_sel=2.
//   2. ro_in[0] constant 0, sel=0, window=500 -> count=0. ro_en=8'b0000_0001 during SETTLE/MEASURE only.
//   3. sel=9 (NUM_RO=8) -> no ro_en activity, valid after 2 cycles, count=0, err=1.
//   4. CNT_W=4, ro period 4, window=200 -> count=15, ovf=1.
//   5. result_ready held 0 for 50 cycles, second start mid-wait -> valid/result stable, start ignored.
//      Ready -> IDLE and busy=0 next cycle.
//   6. ARESET at MEASURE cycle 300 -> next cycle all outputs 0, FSM IDLE, no valid.
//      A new start then completes normally. window=0 gives count=0.

Source files
------------

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator frequency measurement: enables one RO, lets it settle, counts its synchronised
// rising edges over a programmed ACLK window and hands the result out over a valid/ready pair.
module ro_measure_ctrl #(
  parameter int NUM_RO     = 8,
  parameter int SEL_W      = 4,
  parameter int WIN_W      = 24,
  parameter int CNT_W      = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic              i_aclk,
  input  logic              i_areset,
  input  logic [NUM_RO-1:0] i_ro_in,
  input  logic              i_start,
  input  logic [SEL_W-1:0]  i_ro_sel,
  input  logic [WIN_W-1:0]  i_window_cycles,
  output logic [NUM_RO-1:0] o_ro_en,
  output logic              o_busy,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [CNT_W-1:0]  o_result_count,
  output logic [SEL_W-1:0]  o_result_sel,
  output logic              o_result_ovf,
  output logic              o_result_err
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SEL_W:0] NUM_RO_W = (SEL_W + 1)'(NUM_RO);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [WIN_W-1:0]    r_win_len;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;
  logic                r_err;
  logic                r_s1, r_s2, r_s3;
  logic [NUM_RO-1:0]   r_ro_en;
  logic                r_busy;
  logic                r_valid;
  logic [CNT_W-1:0]    r_res_count;
  logic [SEL_W-1:0]    r_res_sel;
  logic                r_res_ovf;
  logic                r_res_err;

  logic                w_ro_mux;
  logic                w_edge;
  logic                w_start_ok;
  logic [NUM_RO-1:0]   w_start_onehot;

  assign w_start_ok = ({1'b0, i_ro_sel} < NUM_RO_W);

  always_comb begin
    w_ro_mux       = 1'b0;
    w_start_onehot = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (r_sel == SEL_W'(i)) w_ro_mux = i_ro_in[i];
      if (i_ro_sel == SEL_W'(i)) w_start_onehot[i] = 1'b1;
    end
  end

  // Mux sits ahead of the synchroniser so only one RO crosses into the ACLK domain.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= w_ro_mux;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_win_len    <= '0;
      r_win_cnt    <= '0;
      r_settle_cnt <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_ro_en      <= '0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_res_count  <= '0;
      r_res_sel    <= '0;
      r_res_ovf    <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sel        <= i_ro_sel;
            r_win_len    <= i_window_cycles;
            r_busy       <= 1'b1;
            r_settle_cnt <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            if (w_start_ok) begin
              r_err   <= 1'b0;
              r_ro_en <= w_start_onehot;
              r_state <= ST_SETTLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            if (r_win_len == '0) begin
              r_ro_en <= '0;
              r_state <= ST_DONE;
            end else begin
              r_win_cnt <= r_win_len;
              r_count   <= '0;
              r_ovf     <= 1'b0;
              r_state   <= ST_MEASURE;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            if (r_count == CNT_MAX) r_ovf <= 1'b1;
            else                    r_count <= r_count + CNT_W'(1);
          end
          r_win_cnt <= r_win_cnt - WIN_W'(1);
          if (r_win_cnt == WIN_W'(1)) begin
            r_ro_en <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle captures the result; valid then holds until the consumer takes it.
          if (!r_valid) begin
            r_valid     <= 1'b1;
            r_res_count <= r_count;
            r_res_sel   <= r_sel;
            r_res_ovf   <= r_ovf;
            r_res_err   <= r_err;
          end else if (i_result_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ro_en        = r_ro_en;
  assign o_busy         = r_busy;
  assign o_result_valid = r_valid;
  assign o_result_count = r_res_count;
  assign o_result_sel   = r_res_sel;
  assign o_result_ovf   = r_res_ovf;
  assign o_result_err   = r_res_err;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl: table vectors, random RO activity against an edge-counting model,
// plus hand sequences for result back-pressure and mid-measurement reset.
module tb_ro_measure_ctrl;
  localparam int NUM_RO = 8;
  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ro_in = '0;
  logic        start;
  logic [3:0]  ro_sel;
  logic [23:0] win;
  logic        ready;

  logic [7:0]  ro_en, ro_en4;
  logic        busy, valid, ovf, err;
  logic [31:0] cnt;
  logic [3:0]  rsel;
  logic        busy4, valid4, ovf4, err4;
  logic [3:0]  cnt4, rsel4;

  ro_measure_ctrl dut (
    .i_aclk(clk), .i_areset(rst), .i_ro_in(ro_in), .i_start(start), .i_ro_sel(ro_sel),
    .i_window_cycles(win), .o_ro_en(ro_en), .o_busy(busy), .o_result_valid(valid),
    .i_result_ready(ready), .o_result_count(cnt), .o_result_sel(rsel),
    .o_result_ovf(ovf), .o_result_err(err)
  );

  ro_measure_ctrl #(.CNT_W(4)) dut4 (
    .i_aclk(clk), .i_areset(rst), .i_ro_in(ro_in), .i_start(start), .i_ro_sel(ro_sel),
    .i_window_cycles(win), .o_ro_en(ro_en4), .o_busy(busy4), .o_result_valid(valid4),
    .i_result_ready(ready), .o_result_count(cnt4), .o_result_sel(rsel4),
    .o_result_ovf(ovf4), .o_result_err(err4)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  logic [7:0] samp [0:32767];
  always @(posedge clk) begin
    samp[cyc] = ro_in;
    cyc++;
  end

  int half = 0;
  bit ro_rand = 0;
  always @(negedge clk) begin
    if (ro_rand)        ro_in = 8'($urandom);
    else if (half == 0) ro_in = '0;
    else if (cyc % half == 0) ro_in = ~ro_in;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
    n_chk++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Rising edges of the selected RO as sampled by ACLK. Counting opens SETTLE cycles after the
  // start edge and the 2-flop synchroniser delays detection by two edges, so the sampled window
  // is [s+SETTLE-1, s+SETTLE-2+w]; edges still in the pipe when it closes are lost.
  function automatic longint model_cnt(input int sel, input int s, input int w);
    longint n = 0;
    if (sel >= NUM_RO || w == 0) return 0;
    for (int j = s + SETTLE - 1; j <= s + SETTLE - 2 + w; j++)
      if (samp[j][sel] && !samp[j-1][sel]) n++;
    return n;
  endfunction

  // Issues a start and waits (bounded) for result_valid, tracking ro_en/busy on the way.
  task automatic run_meas(input int sel, input int w, output int s);
    logic [7:0] exp_en;
    bit en_bad = 0, busy_bad = 0;
    int lat = -1, d;
    @(negedge clk);
    start = 1'b1; ro_sel = 4'(sel); win = 24'(w); s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < w + 100; k++) begin
      d = cyc - s;
      if (valid) begin
        lat = d;
        break;
      end
      exp_en = (sel < NUM_RO && d >= 1 && d <= SETTLE + w) ? 8'(1 << sel) : 8'h00;
      if (ro_en !== exp_en) en_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
    end
    check("start_to_valid_latency", lat, (sel >= NUM_RO) ? 2 : w + SETTLE + 2);
    check("ro_en_window", en_bad, 0);
    check("busy_while_running", busy_bad, 0);
  endtask

  task automatic finish_hs(input longint exp_cnt);
    @(negedge clk);
    check("valid_after_handshake", valid, 0);
    check("busy_after_handshake", busy, 0);
    check("count_held_after_handshake", cnt, exp_cnt);
  endtask

  typedef struct {
    int sel; int win; int half;
    int exp_cnt; int tol; bit exp_err;
    int exp_cnt4; bit exp_ovf4;
  } vec_t;

  vec_t tab [6];

  initial begin
    int s;
    longint m;
    bit bad;
    logic [31:0] hold_cnt;
    logic [3:0]  hold_sel;

    tab[0] = '{sel: 2, win: 1000, half: 5, exp_cnt: 100, tol: 1, exp_err: 0, exp_cnt4: 15, exp_ovf4: 1};
    tab[1] = '{sel: 0, win: 500,  half: 0, exp_cnt: 0,   tol: 0, exp_err: 0, exp_cnt4: 0,  exp_ovf4: 0};
    tab[2] = '{sel: 9, win: 50,   half: 5, exp_cnt: 0,   tol: 0, exp_err: 1, exp_cnt4: 0,  exp_ovf4: 0};
    tab[3] = '{sel: 5, win: 200,  half: 2, exp_cnt: 50,  tol: 1, exp_err: 0, exp_cnt4: 15, exp_ovf4: 1};
    tab[4] = '{sel: 7, win: 0,    half: 3, exp_cnt: 0,   tol: 0, exp_err: 0, exp_cnt4: 0,  exp_ovf4: 0};
    tab[5] = '{sel: 3, win: 300,  half: 3, exp_cnt: 50,  tol: 1, exp_err: 0, exp_cnt4: 15, exp_ovf4: 1};

    rst = 1'b1; start = 1'b0; ro_sel = '0; win = '0; ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {ro_en, busy, valid, cnt, rsel, ovf, err}, '0);
    check("reset_outputs_cnt4", {ro_en4, busy4, valid4, cnt4, rsel4, ovf4, err4}, '0);

    foreach (tab[i]) begin
      half = tab[i].half; ro_rand = 0;
      repeat (3) @(negedge clk);
      run_meas(tab[i].sel, tab[i].win, s);
      m = model_cnt(tab[i].sel, s, tab[i].win);
      check_tol("tab_count", cnt, tab[i].exp_cnt, tab[i].tol);
      check("tab_count_model", cnt, m);
      check("tab_err", err, tab[i].exp_err);
      check("tab_sel", rsel, tab[i].sel);
      check("tab_ovf", ovf, 0);
      check("tab_count_cnt4", cnt4, tab[i].exp_cnt4);
      check("tab_ovf_cnt4", ovf4, tab[i].exp_ovf4);
      finish_hs(m);
    end

    ro_rand = 1;
    for (int r = 0; r < 12; r++) begin
      int sel, w;
      sel = $urandom_range(0, 9);
      w = $urandom_range(0, 60);
      run_meas(sel, w, s);
      m = model_cnt(sel, s, w);
      check("rand_count", cnt, m);
      check("rand_err", err, sel >= NUM_RO);
      check("rand_sel", rsel, sel);
      check("rand_ovf", ovf, 0);
      check("rand_count_cnt4", cnt4, (m > 15) ? 15 : m);
      check("rand_ovf_cnt4", ovf4, m > 15);
      finish_hs(m);
    end

    // Consumer stalls 50 cycles; a second start during the stall must be ignored.
    ro_rand = 0; half = 5; ready = 1'b0;
    run_meas(1, 40, s);
    m = model_cnt(1, s, 40);
    hold_cnt = 32'(m); hold_sel = 4'd1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      start = (k == 20);
      if (k == 20) begin ro_sel = 4'd3; win = 24'd10; end
      @(negedge clk);
      if (valid !== 1'b1 || busy !== 1'b1 || cnt !== hold_cnt || rsel !== hold_sel) bad = 1;
    end
    start = 1'b0;
    check("stall_result_stable", bad, 0);
    check("stall_count", cnt, m);
    ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", valid, 0);
    check("stall_release_busy", busy, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || valid !== 1'b0) bad = 1;
    end
    check("ignored_start_no_run", bad, 0);

    // Reset 300 cycles into the measurement window aborts without a result.
    @(negedge clk);
    start = 1'b1; ro_sel = 4'd2; win = 24'd1000; s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s < SETTLE + 1 + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {ro_en, busy, valid, cnt, rsel, ovf, err}, '0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0 || ro_en !== 8'h00) bad = 1;
    end
    check("abort_no_result", bad, 0);
    run_meas(4, 0, s);
    check("post_abort_count", cnt, 0);
    check("post_abort_err", err, 0);
    check("post_abort_sel", rsel, 4);
    finish_hs(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
